// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Brief    : Receive-side FWFT byte buffer behind a UART receiver, with
//             sticky overrun flag and saturating parity-error counter.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter bit DROP_PAR_ERR = 1'b0
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_data_valid,
  input  logic [DATA_WIDTH-1:0]      i_P_DATA,
  input  logic                       i_par_err,
  input  logic                       i_rd_ready,
  input  logic                       i_clr_status,
  output logic                       o_rd_valid,
  output logic [DATA_WIDTH-1:0]      o_rd_data,
  output logic                       o_rd_par_err,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_overrun,
  output logic [7:0]                 o_par_err_cnt
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [7:0]    CNT_MAX = 8'hFF;

  // Each entry holds {par_err, data}; the array itself is never reset.
  logic [DATA_WIDTH:0] mem [DEPTH];

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic        full;
  logic        empty;
  logic        wr_req;
  logic        wr_fire;
  logic        rd_fire;
  logic        ovr_evt;
  logic        pe_evt;
  logic [DATA_WIDTH:0] head;

  // Flags from pointers: MSB is the wrap bit distinguishing full from empty.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    rd_fire = !empty && i_rd_ready;
    wr_req  = i_data_valid && !(DROP_PAR_ERR && i_par_err);
    // A full FIFO still accepts a write when the head is popped in the same cycle.
    wr_fire = wr_req && (!full || rd_fire);
    ovr_evt = wr_req && full && !rd_fire;
    pe_evt  = i_data_valid && i_par_err;
  end

  // First-word-fall-through head: outputs read straight from the array, zero while empty.
  always_comb begin
    head = mem[rd_ptr[AW-1:0]];
    if (empty) begin
      head = '0;
    end
  end

  assign o_rd_valid    = !empty;
  assign o_rd_data     = head[DATA_WIDTH-1:0];
  assign o_rd_par_err  = head[DATA_WIDTH];
  assign o_count       = count;
  assign o_full        = full;
  assign o_empty       = empty;

  // Storage write port.
  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      mem[wr_ptr[AW-1:0]] <= {i_par_err, i_P_DATA};
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + PTR_ONE;
        2'b01:   count <= count - PTR_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky overrun flag; a new overrun in the clearing cycle keeps it set.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_overrun <= 1'b0;
    end else if (ovr_evt) begin
      o_overrun <= 1'b1;
    end else if (i_clr_status) begin
      o_overrun <= 1'b0;
    end
  end

  // Saturating parity-error counter; counts every flagged frame, stored or not.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_par_err_cnt <= '0;
    end else if (i_clr_status) begin
      o_par_err_cnt <= pe_evt ? 8'd1 : 8'd0;
    end else if (pe_evt && (o_par_err_cnt != CNT_MAX)) begin
      o_par_err_cnt <= o_par_err_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Brief    : Directed self-checking bench for uart_rx_fifo (store and drop
//             parity-error variants driven in parallel).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       data_valid;
  logic [7:0] p_data;
  logic       par_err;
  logic       rd_ready;
  logic       clr_status;

  logic       a_rd_valid, a_rd_par_err, a_full, a_empty, a_overrun;
  logic [7:0] a_rd_data, a_pec;
  logic [4:0] a_count;
  logic       b_rd_valid, b_rd_par_err, b_full, b_empty, b_overrun;
  logic [7:0] b_rd_data, b_pec;
  logic [4:0] b_count;

  int tests = 0;
  int fails = 0;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .DROP_PAR_ERR(1'b0)) dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_data_valid(data_valid), .i_P_DATA(p_data),
    .i_par_err(par_err), .i_rd_ready(rd_ready), .i_clr_status(clr_status),
    .o_rd_valid(a_rd_valid), .o_rd_data(a_rd_data), .o_rd_par_err(a_rd_par_err),
    .o_count(a_count), .o_full(a_full), .o_empty(a_empty),
    .o_overrun(a_overrun), .o_par_err_cnt(a_pec)
  );

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .DROP_PAR_ERR(1'b1)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_data_valid(data_valid), .i_P_DATA(p_data),
    .i_par_err(par_err), .i_rd_ready(rd_ready), .i_clr_status(clr_status),
    .o_rd_valid(b_rd_valid), .o_rd_data(b_rd_data), .o_rd_par_err(b_rd_par_err),
    .o_count(b_count), .o_full(b_full), .o_empty(b_empty),
    .o_overrun(b_overrun), .o_par_err_cnt(b_pec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write pulse, then inputs back to idle.
  task automatic wr(input logic [7:0] d, input logic pe);
    data_valid = 1'b1;
    p_data     = d;
    par_err    = pe;
    tick();
    data_valid = 1'b0;
    par_err    = 1'b0;
  endtask

  // Check head then pop it.
  task automatic rd_chk(input string tag, input logic [7:0] d);
    chk(tag, {24'd0, a_rd_data}, {24'd0, d});
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] k;

    data_valid = 1'b0; p_data = 8'h00; par_err = 1'b0;
    rd_ready = 1'b0; clr_status = 1'b0; rst_n = 1'b0;
    #23;
    chk("rst_count", {27'd0, a_count}, 32'd0);
    chk("rst_empty", {31'd0, a_empty}, 32'd1);
    chk("rst_full", {31'd0, a_full}, 32'd0);
    chk("rst_valid", {31'd0, a_rd_valid}, 32'd0);
    chk("rst_overrun", {31'd0, a_overrun}, 32'd0);
    chk("rst_pec", {24'd0, a_pec}, 32'd0);
    chk("rst_data", {24'd0, a_rd_data}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single byte falls through with no read latency
    wr(8'hA5, 1'b0);
    chk("t1_valid", {31'd0, a_rd_valid}, 32'd1);
    chk("t1_data", {24'd0, a_rd_data}, 32'hA5);
    chk("t1_count", {27'd0, a_count}, 32'd1);
    rd_chk("t1_pop", 8'hA5);
    chk("t1_empty", {31'd0, a_empty}, 32'd1);

    // 2: fill, overrun, drain in order
    for (int i = 0; i < 16; i++) wr(i[7:0], 1'b0);
    chk("t2_full", {31'd0, a_full}, 32'd1);
    chk("t2_count", {27'd0, a_count}, 32'd16);
    chk("t2_ovr_before", {31'd0, a_overrun}, 32'd0);
    wr(8'hFF, 1'b0);
    chk("t2_overrun", {31'd0, a_overrun}, 32'd1);
    chk("t2_count_ovr", {27'd0, a_count}, 32'd16);
    for (int i = 0; i < 16; i++) rd_chk("t2_order", i[7:0]);
    chk("t2_empty", {31'd0, a_empty}, 32'd1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("t2_clr", {31'd0, a_overrun}, 32'd0);

    // 3: write into full FIFO while popping
    for (int i = 0; i < 16; i++) wr(8'h10 + i[7:0], 1'b0);
    rd_ready = 1'b1;
    wr(8'h55, 1'b0);
    rd_ready = 1'b0;
    chk("t3_count", {27'd0, a_count}, 32'd16);
    chk("t3_overrun", {31'd0, a_overrun}, 32'd0);
    chk("t3_full", {31'd0, a_full}, 32'd1);
    for (int i = 1; i < 16; i++) rd_chk("t3_order", 8'h10 + i[7:0]);
    rd_chk("t3_last", 8'h55);
    chk("t3_empty", {31'd0, a_empty}, 32'd1);

    // 4: parity-error byte stored (A) vs dropped (B)
    wr(8'h3C, 1'b1);
    chk("t4a_data", {24'd0, a_rd_data}, 32'h3C);
    chk("t4a_pe", {31'd0, a_rd_par_err}, 32'd1);
    chk("t4a_pec", {24'd0, a_pec}, 32'd1);
    chk("t4b_count", {27'd0, b_count}, 32'd0);
    chk("t4b_empty", {31'd0, b_empty}, 32'd1);
    chk("t4b_pec", {24'd0, b_pec}, 32'd1);
    rd_chk("t4a_pop", 8'h3C);

    // 5: counter saturates, then clear concurrent with new error yields 1
    rd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wr(i[7:0], 1'b1);
      tick();
    end
    chk("t5_sat_a", {24'd0, a_pec}, 32'd255);
    chk("t5_sat_b", {24'd0, b_pec}, 32'd255);
    clr_status = 1'b1;
    wr(8'h77, 1'b1);
    clr_status = 1'b0;
    chk("t5_clr_a", {24'd0, a_pec}, 32'd1);
    chk("t5_clr_b", {24'd0, b_pec}, 32'd1);
    tick();
    rd_ready = 1'b0;
    chk("t5_empty", {31'd0, a_empty}, 32'd1);

    // 6: asynchronous reset with 5 entries stored and overrun set
    for (int i = 0; i < 17; i++) wr(8'h80 + i[7:0], 1'b0);
    for (int i = 0; i < 11; i++) rd_chk("t6_pre", 8'h80 + i[7:0]);
    chk("t6_count5", {27'd0, a_count}, 32'd5);
    chk("t6_ovr_set", {31'd0, a_overrun}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_count", {27'd0, a_count}, 32'd0);
    chk("t6_rst_empty", {31'd0, a_empty}, 32'd1);
    chk("t6_rst_ovr", {31'd0, a_overrun}, 32'd0);
    #3 rst_n = 1'b1;
    tick();

    // 6b: streaming across pointer wrap against a queue model
    for (int i = 0; i < 3; i++) begin
      k = 8'hC0 + i[7:0];
      wr(k, 1'b0);
      q.push_back(k);
    end
    for (int i = 0; i < 40; i++) begin
      k = 8'h20 + i[7:0];
      chk("t6_wrap_data", {24'd0, a_rd_data}, {24'd0, q[0]});
      data_valid = 1'b1;
      p_data     = k;
      rd_ready   = 1'b1;
      tick();
      void'(q.pop_front());
      q.push_back(k);
    end
    data_valid = 1'b0;
    rd_ready   = 1'b0;
    chk("t6_wrap_count", {27'd0, a_count}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
